timer_irq_ctrl: RTL

TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

---
 rtl/timer_irq_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt controller: latches overflow/compare pulses into pending bits,
// arbitrates enabled sources round-robin and runs a REQ/ack/SERVICE/eoi handshake.
module timer_irq_ctrl #(
  parameter int NUM_TIMERS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_TIMERS-1:0] overflow_int,
  input  logic [NUM_TIMERS-1:0] compare_int,
  input  logic [7:0]            enable_in,
  input  logic                  enable_write,
  input  logic [7:0]            clear_in,
  input  logic                  clear_write,
  output logic [7:0]            enable_out,
  output logic [7:0]            pending_out,
  output logic [7:0]            overrun_out,
  output logic                  irq_req,
  output logic [2:0]            irq_vector,
  input  logic                  irq_ack,
  input  logic                  irq_eoi,
  output logic                  irq_active
);

  localparam int         NUM_SRC  = 2 * NUM_TIMERS;
  localparam logic [7:0] SRC_MASK = 8'((16'h0001 << NUM_SRC) - 16'h0001);
  localparam logic [2:0] LAST_SRC = 3'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] enable_q, enable_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] overrun_q, overrun_d;
  logic [2:0] vector_q, vector_d;
  logic [2:0] last_grant_q, last_grant_d;
  logic       irq_req_q, irq_active_q;

  logic [7:0] src_pulse;
  logic [7:0] clr_mask;
  logic [7:0] ack_mask;
  logic [7:0] pend_live;
  logic [7:0] req_vec;
  logic [2:0] rr_start;
  logic [3:0] rr_idx;
  logic [2:0] rr_vec;
  logic       rr_found;

  // Map timer pulses onto source numbers: even = overflow, odd = compare.
  always_comb begin
    src_pulse = 8'h00;
    for (int t = 0; t < NUM_TIMERS; t++) begin
      src_pulse[2*t]   = overflow_int[t];
      src_pulse[2*t+1] = compare_int[t];
    end
  end

  assign req_vec  = pending_q & enable_q;
  assign rr_start = (last_grant_q == LAST_SRC) ? 3'd0 : last_grant_q + 3'd1;

  // Round-robin search over enabled pending sources, starting after the last grant.
  always_comb begin
    rr_found = 1'b0;
    rr_vec   = 3'd0;
    rr_idx   = 4'd0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rr_idx = {1'b0, rr_start} + 4'(k);
      if (rr_idx >= 4'(NUM_SRC)) begin
        rr_idx = rr_idx - 4'(NUM_SRC);
      end else begin
        rr_idx = rr_idx;
      end
      if (!rr_found && req_vec[rr_idx[2:0]]) begin
        rr_found = 1'b1;
        rr_vec   = rr_idx[2:0];
      end else begin
        rr_found = rr_found;
      end
    end
  end

  // Next-state logic for the handshake FSM and the source registers.
  always_comb begin
    clr_mask     = clear_write ? clear_in : 8'h00;
    // A same-cycle software clear withdraws the request before an ack can take it.
    pend_live    = (pending_q & ~clr_mask) | src_pulse;
    state_d      = state_q;
    vector_d     = vector_q;
    last_grant_d = last_grant_q;
    ack_mask     = 8'h00;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d  = REQ;
          vector_d = rr_vec;
        end else begin
          state_d  = IDLE;
        end
      end
      REQ: begin
        if (!pend_live[vector_q] || !enable_q[vector_q]) begin
          state_d = IDLE;
        end else if (irq_ack) begin
          state_d      = SERVICE;
          last_grant_d = vector_q;
          ack_mask     = 8'h01 << vector_q;
        end else begin
          state_d = REQ;
        end
      end
      SERVICE: begin
        if (irq_eoi) begin
          state_d = IDLE;
        end else begin
          state_d = SERVICE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    enable_d  = enable_write ? (enable_in & SRC_MASK) : enable_q;
    pending_d = ((pending_q & ~clr_mask & ~ack_mask) | src_pulse) & SRC_MASK;
    overrun_d = ((overrun_q & ~clr_mask) | (src_pulse & pending_q)) & SRC_MASK;
  end

  // State and output registers; synchronous reset overrides every event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      enable_q     <= 8'h00;
      pending_q    <= 8'h00;
      overrun_q    <= 8'h00;
      vector_q     <= 3'd0;
      last_grant_q <= LAST_SRC;
      irq_req_q    <= 1'b0;
      irq_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      vector_q     <= vector_d;
      last_grant_q <= last_grant_d;
      irq_req_q    <= (state_d == REQ);
      irq_active_q <= (state_d == SERVICE);
    end
  end

  assign enable_out  = enable_q;
  assign pending_out = pending_q;
  assign overrun_out = overrun_q;
  assign irq_req     = irq_req_q;
  assign irq_vector  = vector_q;
  assign irq_active  = irq_active_q;

endmodule
